// File: rtl/mdu_if.sv
// Request/response bundle between the execute stage and the iterative multiply/divide sequencer.
interface mdu_if #(
    parameter int XLEN = 64
);
    logic            start;
    logic            flush;
    logic [2:0]      op_sel;
    logic            is_word_opt;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            ready;
    logic            stall_req;
    logic            out_valid;
    logic [XLEN-1:0] mdu_output;

    modport master (
        output start, flush, op_sel, is_word_opt, op1, op2,
        input  ready, stall_req, out_valid, mdu_output
    );

    modport slave (
        input  start, flush, op_sel, is_word_opt, op1, op2,
        output ready, stall_req, out_valid, mdu_output
    );
endinterface

// File: rtl/exe_stage_mdu_ctrl.sv
// Iterative RV64M sequencer: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Optional macro MDU_FAST_ZERO_EN: multiplies with a zero operand skip the iteration loop.
module exe_stage_mdu_ctrl #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic clk,
    input  logic rst,
    mdu_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        opsel_q, opsel_d;
    logic              word_q, word_d;
    logic [XLEN-1:0]   op1_q, op1_d, op2_q, op2_d;
    logic [XLEN-1:0]   opb_q, opb_d, quo_q, quo_d, rem_q, rem_d, out_q, out_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic              neg_q, neg_d, rneg_q, rneg_d;

    function automatic logic [XLEN-1:0] sext_w(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    // operand extraction, magnitudes and special-case detection (used in PREP)
    logic            is_mul, mul_hi, a_sgn, b_sgn, s1, s2, div_zero, div_ovf, fast_zero;
    logic [XLEN-1:0] x1, x2, m1, m2, min_neg;

    assign is_mul   = ~opsel_q[2];
    assign mul_hi   = is_mul & ~word_q & (opsel_q[1:0] != 2'd0);
    assign a_sgn    = is_mul ? (word_q | (opsel_q[1:0] != 2'd3)) : ~opsel_q[0];
    assign b_sgn    = is_mul ? (word_q | ~opsel_q[1]) : ~opsel_q[0];
    assign x1       = word_q ? {{(XLEN-32){a_sgn & op1_q[31]}}, op1_q[31:0]} : op1_q;
    assign x2       = word_q ? {{(XLEN-32){b_sgn & op2_q[31]}}, op2_q[31:0]} : op2_q;
    assign s1       = a_sgn & x1[XLEN-1];
    assign s2       = b_sgn & x2[XLEN-1];
    assign m1       = s1 ? -x1 : x1;
    assign m2       = s2 ? -x2 : x2;
    assign min_neg  = word_q ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    assign div_zero = ~is_mul & (x2 == '0);
    assign div_ovf  = ~is_mul & ~opsel_q[0] & (x1 == min_neg) & (x2 == '1);
`ifdef MDU_FAST_ZERO_EN
    assign fast_zero = is_mul & ((x1 == '0) | (x2 == '0));
`else
    assign fast_zero = 1'b0;
`endif

    // one iteration of each algorithm (used in CALC)
    logic [XLEN:0] psum, rem_sh;
    logic          no_borrow;

    assign psum      = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opb_q} : '0);
    assign rem_sh    = {rem_q, quo_q[XLEN-1]};
    assign no_borrow = rem_sh >= {1'b0, opb_q};

    // sign fix-up and result selection (used in FIX); word products sit 32 bits up
    logic [2*XLEN-1:0] prod_n;
    logic [XLEN-1:0]   quo_n, rem_n, res_raw, res;

    assign prod_n  = neg_q ? -prod_q : prod_q;
    assign quo_n   = neg_q ? -quo_q : quo_q;
    assign rem_n   = rneg_q ? -rem_q : rem_q;
    assign res_raw = is_mul ? (word_q ? prod_n[XLEN+31:32]
                                      : (mul_hi ? prod_n[2*XLEN-1:XLEN] : prod_n[XLEN-1:0]))
                            : (opsel_q[1] ? rem_n : quo_n);
    assign res     = word_q ? sext_w(res_raw[31:0]) : res_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            opsel_q <= '0;
            word_q  <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            opb_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            prod_q  <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opsel_q <= opsel_d;
            word_q  <= word_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            opb_q   <= opb_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            prod_q  <= prod_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_PREP;
            S_PREP:  state_d = (div_zero | div_ovf | fast_zero) ? S_FIX : S_CALC;
            S_CALC:  if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        if (bus.flush) state_d = S_IDLE;
    end

    always_comb begin
        cnt_d   = cnt_q;
        opsel_d = opsel_q;
        word_d  = word_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        opb_d   = opb_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        prod_d  = prod_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        out_d   = out_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    opsel_d = bus.op_sel;
                    word_d  = bus.is_word_opt;
                    op1_d   = bus.op1;
                    op2_d   = bus.op2;
                end
            end
            S_PREP: begin
                cnt_d  = word_q ? CNT_W'(32) : CNT_W'(XLEN);
                neg_d  = s1 ^ s2;
                rneg_d = s1;
                if (is_mul) begin
                    opb_d  = m1;
                    prod_d = fast_zero ? '0 : {{XLEN{1'b0}}, m2};
                end else if (div_zero) begin
                    quo_d  = '1;
                    rem_d  = x1;
                    neg_d  = 1'b0;
                    rneg_d = 1'b0;
                end else if (div_ovf) begin
                    quo_d  = x1;
                    rem_d  = '0;
                    neg_d  = 1'b0;
                    rneg_d = 1'b0;
                end else begin
                    // word dividends are pre-shifted so 32 iterations consume exactly their bits
                    opb_d = m2;
                    quo_d = word_q ? {m1[31:0], 32'b0} : m1;
                    rem_d = '0;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (is_mul) begin
                    prod_d = {psum, prod_q[XLEN-1:1]};
                end else begin
                    quo_d = {quo_q[XLEN-2:0], no_borrow};
                    rem_d = no_borrow ? (rem_sh[XLEN-1:0] - opb_q) : rem_sh[XLEN-1:0];
                end
            end
            S_FIX: begin
                if (!bus.flush) out_d = res;
            end
            default: ;
        endcase
    end

    assign bus.ready      = (state_q == S_IDLE);
    assign bus.out_valid  = (state_q == S_DONE);
    assign bus.stall_req  = (state_q == S_PREP) || (state_q == S_CALC) || (state_q == S_FIX)
                            || (bus.start && bus.ready);
    assign bus.mdu_output = out_q;
endmodule

// File: tb/tb_exe_stage_mdu_ctrl.sv
// Randomized and directed bench for exe_stage_mdu_ctrl against an arithmetic reference model.
module tb_exe_stage_mdu_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    logic [63:0] last_out = '0;

    always #5 clk = ~clk;

    mdu_if #(.XLEN(64)) bus ();

    exe_stage_mdu_ctrl #(.XLEN(64), .CNT_W(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [63:0] ref_res(input logic [2:0] op, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] ea, eb, p;
        int                  ia, ib;
        int unsigned         wa, wb;
        longint              sa, sb;
        longint unsigned     ua, ub;
        logic [31:0]         r32;
        logic [63:0]         r64;
        if (!op[2]) begin
            if (w) begin
                p = $signed({{96{a[31]}}, a[31:0]}) * $signed({{96{b[31]}}, b[31:0]});
                return {{32{p[31]}}, p[31:0]};
            end
            ea = (op != 3'd3) ? {{64{a[63]}}, a} : {64'b0, a};
            eb = (op <= 3'd1) ? {{64{b[63]}}, b} : {64'b0, b};
            p  = ea * eb;
            return (op == 3'd0) ? p[63:0] : p[127:64];
        end
        if (w) begin
            ia = a[31:0]; ib = b[31:0]; wa = a[31:0]; wb = b[31:0];
            if (b[31:0] == 32'd0)                                  r32 = op[1] ? a[31:0] : 32'hFFFF_FFFF;
            else if (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                                                                   r32 = op[1] ? 32'd0 : a[31:0];
            else if (!op[0])                                       r32 = op[1] ? ia % ib : ia / ib;
            else                                                   r32 = op[1] ? wa % wb : wa / wb;
            return {{32{r32[31]}}, r32};
        end
        sa = a; sb = b; ua = a; ub = b;
        if (b == 64'd0)                                            r64 = op[1] ? a : '1;
        else if (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1) r64 = op[1] ? 64'd0 : a;
        else if (!op[0])                                           r64 = op[1] ? sa % sb : sa / sb;
        else                                                       r64 = op[1] ? ua % ub : ua / ub;
        return r64;
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
        logic dz, ov;
        dz = w ? (b[31:0] == 32'd0) : (b == 64'd0);
        ov = !op[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                          : (a == 64'h8000_0000_0000_0000 && b == '1));
        if (op[2] && (dz || ov)) return 3;
        return w ? 35 : 67;
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 6))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'hFFFF_FFFF_8000_0000;
            4:       return 64'($urandom_range(0, 20));
            5:       return {32'd0, 32'($urandom)};
            default: return {32'($urandom), 32'($urandom)};
        endcase
    endfunction

    // Caller is in an IDLE cycle, before the rising edge; the op is accepted at that edge.
    task automatic run_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input bit junk, input string name);
        logic [63:0] exp_v;
        int          exp_lat;
        bit          seen;
        exp_v   = ref_res(op, w, a, b);
        exp_lat = ref_lat(op, w, a, b);
        bus.start = 1'b1; bus.flush = 1'b0; bus.op_sel = op; bus.is_word_opt = w;
        bus.op1 = a; bus.op2 = b;
        #1;
        n_vec++;
        if (bus.ready !== 1'b1 || bus.stall_req !== 1'b1) begin
            n_err++;
            $display("FAIL %s accept: ready=%b stall_req=%b, required 1 1", name, bus.ready, bus.stall_req);
        end
        seen = 0;
        for (int k = 1; k <= 80 && !seen; k++) begin
            @(negedge clk);
            bus.start = junk ? 1'($urandom) : 1'b0;
            if (junk) begin
                bus.op_sel = 3'($urandom); bus.is_word_opt = 1'($urandom); bus.op1 = pick(); bus.op2 = pick();
            end
            #1;
            if (bus.out_valid === 1'b1) begin
                seen = 1;
                bus.start = 1'b0;
                n_vec++;
                if (k != exp_lat) begin
                    n_err++;
                    $display("FAIL %s latency: got %0d cycles, required %0d", name, k, exp_lat);
                end
                n_vec++;
                if (bus.mdu_output !== exp_v) begin
                    n_err++;
                    $display("FAIL %s result: op=%0d w=%b a=%h b=%h got %h required %h",
                             name, op, w, a, b, bus.mdu_output, exp_v);
                end
                n_vec++;
                if (bus.stall_req !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s done_stall: stall_req=%b, required 0", name, bus.stall_req);
                end
            end else begin
                n_vec++;
                if (bus.stall_req !== 1'b1 || bus.ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s busy cycle %0d: stall_req=%b ready=%b, required 1 0",
                             name, k, bus.stall_req, bus.ready);
                end
            end
        end
        if (!seen) begin
            n_vec++; n_err++;
            $display("FAIL %s timeout: no out_valid within 80 cycles, required at %0d", name, exp_lat);
        end
        bus.start = 1'b0;
        @(negedge clk);
        #1;
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.ready !== 1'b1 || bus.mdu_output !== exp_v) begin
            n_err++;
            $display("FAIL %s after_done: out_valid=%b ready=%b out=%h, required 0 1 %h",
                     name, bus.out_valid, bus.ready, bus.mdu_output, exp_v);
        end
        last_out = exp_v;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b0; bus.flush = 1'b0; bus.op_sel = '0;
        bus.is_word_opt = 1'b0; bus.op1 = '0; bus.op2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        n_vec++;
        if (bus.ready !== 1'b1 || bus.stall_req !== 1'b0 || bus.out_valid !== 1'b0 || bus.mdu_output !== 64'd0) begin
            n_err++;
            $display("FAIL reset: ready=%b stall=%b valid=%b out=%h, required 1 0 0 0",
                     bus.ready, bus.stall_req, bus.out_valid, bus.mdu_output);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_op(3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 0, "mul_3_m5");
        run_op(3'd3, 1'b0, '1, '1, 0, "mulhu_ones");
        run_op(3'd4, 1'b0, 64'd100, 64'd0, 0, "div_by_zero");
        run_op(3'd7, 1'b0, 64'd100, 64'd0, 0, "remu_by_zero");
        run_op(3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 0, "divw_ovf");
        run_op(3'd6, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 0, "remw_ovf");
        run_op(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, "rem_m7_2");
        run_op(3'd5, 1'b1, 64'hFFFF_FFFF, 64'd2, 0, "divuw");
        run_op(3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 0, "div_ovf64");
        run_op(3'd2, 1'b0, '1, '1, 0, "mulhsu_m1");
        run_op(3'd1, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h8765_4321_0FED_CBA9, 0, "mulh_w_as_mulw");
    endtask

    task automatic test_flush();
        bus.start = 1'b1; bus.op_sel = 3'd4; bus.is_word_opt = 1'b0;
        bus.op1 = 64'd1000; bus.op2 = 64'd7;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            n_vec++;
            if (bus.out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL flush_pre cycle %0d: out_valid=%b, required 0", k, bus.out_valid);
            end
            if (k == 10) bus.flush = 1'b1;
        end
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        n_vec++;
        if (bus.ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.stall_req !== 1'b0 || bus.mdu_output !== last_out) begin
            n_err++;
            $display("FAIL flush_idle: ready=%b valid=%b stall=%b out=%h, required 1 0 0 %h",
                     bus.ready, bus.out_valid, bus.stall_req, bus.mdu_output, last_out);
        end
        run_op(3'd6, 1'b0, 64'd1000, 64'd7, 0, "after_flush");
        // a start coinciding with flush in IDLE must be dropped
        bus.start = 1'b1; bus.flush = 1'b1; bus.op_sel = 3'd0;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        #1;
        n_vec++;
        if (bus.ready !== 1'b1 || bus.stall_req !== 1'b0) begin
            n_err++;
            $display("FAIL flush_vs_start: ready=%b stall=%b, required 1 0", bus.ready, bus.stall_req);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            run_op(3'($urandom), 1'($urandom), pick(), pick(), 0, "random");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++)
            run_op(3'($urandom), 1'($urandom), pick(), pick(), 1, "b2b_junk");
    endtask

    task automatic test_reset_mid();
        bus.start = 1'b1; bus.op_sel = 3'd0; bus.is_word_opt = 1'b0; bus.op1 = 64'd9; bus.op2 = 64'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        if (bus.ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.mdu_output !== 64'd0 || bus.stall_req !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: ready=%b valid=%b out=%h stall=%b, required 1 0 0 0",
                     bus.ready, bus.out_valid, bus.mdu_output, bus.stall_req);
        end
        last_out = '0;
        run_op(3'd7, 1'b0, 64'd1000, 64'd7, 0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_flush();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
